layer_out_serializer: RTL and testbench
=======================================

// Module: layer_out_serializer
// PURPOSE
//  Parallel-to-serial stage placed directly downstream of each Layer_N instance.
//  - Captures the packed NN-neuron output vector when the layer pulses its valid.
//  - Replays the vector one dataWidth word per transfer, with valid/ready flow control.
//  - The replayed stream feeds x_valid/x_in of the next layer.
//  - Flags any capture request that arrives while the previous vector is still draining.
// PARAMETERS
//  NN          30   neurons in the upstream layer = words per frame
//  DATA_WIDTH  16   bits per neuron output word (`dataWidth)
//  CNT_WIDTH   8    width of word index counter; must satisfy 2**CNT_WIDTH > NN
// PORTS
//  s_axi_aclk     in   1              clock
//  reset          in   1              synchronous, active-high reset
//  i_valid        in   1              capture strobe (layer o_valid[0])
//  i_data         in   NN*DATA_WIDTH  packed outputs; neuron 0 in bits [DATA_WIDTH-1:0]
//  o_data         out  DATA_WIDTH     current serial word
//  o_valid        out  1              o_data valid
//  i_ready        in   1              downstream accepts o_data this cycle
//  o_last         out  1              current word is neuron NN-1
//  o_busy         out  1              frame held / draining (state SEND)
//  o_overrun      out  1              1-cycle pulse: capture request dropped
//  o_overrun_cnt  out  16             dropped-capture count
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 on reset: o_data, o_valid, o_last, o_busy, o_overrun, o_overrun_cnt.
//  - Holding register is cleared; word index is cleared.
//  Reset takes priority over every other event, including mid-frame.
//  - Next cycle: state IDLE and o_valid=0.
//  - The partial frame is discarded.
//  States: IDLE, SEND.
//  IDLE
//  - o_valid=0, o_busy=0.
//  - i_valid=1: hold<=i_data, idx<=0, go to SEND.
//  SEND
//  - o_valid=1, o_busy=1.
//  - o_data = hold[DATA_WIDTH-1:0], driven straight from the register (no extra pipeline).
//  - o_last = (idx==NN-1).
//  Transfer = o_valid & i_ready.
//  - On transfer: hold >>= DATA_WIDTH, idx++.
//  - On transfer with o_last=1: go to IDLE.
//  Latency
//  - i_valid in cycle T gives word 0 on o_data with o_valid=1 in cycle T+1.
//  - With i_ready held at 1, words 0..NN-1 appear in T+1..T+NN.
//  - o_valid=0 in T+NN+1, unless the frame is chained.
//  Backpressure
//  - While o_valid=1 and i_ready=0, o_data, o_last and idx stay stable.
//  - No word is ever skipped or repeated.
//  Frame chaining
//  - i_valid in the same cycle as the transfer of the last word captures the new vector.
//  - State stays SEND; the new word 0 appears the next cycle with no bubble.
//  - This is not an overrun.
//  Overrun
//  - i_valid in SEND, other than the chaining case, is ignored.
//  - Draining of the current frame is unaffected.
//  - o_overrun=1 for exactly that cycle (+1 cycle registered).
//  Arithmetic: idx is unsigned; o_overrun_cnt saturates at 16'hFFFF and never wraps.
// CONFIGURATION
//  Macro: LAYER_SER_OVERRUN_CNT_EN
//  - Defined: o_overrun_cnt increments by 1 on each o_overrun pulse (saturating); cleared only by reset.
//  - Undefined: counter logic is not built; o_overrun_cnt is tied to 16'h0000.
//  - o_overrun pulses identically in both builds.
// TESTING (NN=4, DATA_WIDTH=16)
//  1. Capture {16'h0004,16'h0003,16'h0002,16'h0001} at T, i_ready=1
//     -> o_data 1,2,3,4 at T+1..T+4; o_last only at T+4; o_valid=0 at T+5.
//  2. Same frame, i_ready=0 at T+2,T+3
//     -> o_data=2 held stable T+2..T+4; words 3,4 at T+5,T+6; exactly 4 transfers.
//  3. Second i_valid at T+2 with data 16'hAAAA
//     -> o_overrun=1 at T+3; sequence 1..4 unchanged; no 16'hAAAA output.
//     -> o_overrun_cnt=1 with macro, 0 without.
//  4. New frame {8,7,6,5} with i_valid at T+4 (last transfer)
//     -> o_data 5 at T+5, no gap; o_overrun stays 0.
//  5. reset=1 at T+2 mid-frame
//     -> o_valid=0, o_busy=0, o_overrun_cnt=0 at T+3.
//     -> a fresh frame {D,C,B,A} afterwards serializes correctly as A,B,C,D.

Source files
------------

// File: rtl/layer_out_serializer_if.sv
// Stream bundle for layer_out_serializer: capture side (i_valid/i_data) and serial side (o_*/i_ready).
// The slave modport is the serializer's view; the master modport is the view of whatever drives and consumes it.
interface layer_out_serializer_if #(
    parameter int NN         = 30,
    parameter int DATA_WIDTH = 16
);
    logic                       i_valid;
    logic [NN*DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_valid;
    logic                       i_ready;
    logic                       o_last;
    logic                       o_busy;
    logic                       o_overrun;
    logic [15:0]                o_overrun_cnt;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_data, o_valid, o_last, o_busy, o_overrun, o_overrun_cnt
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_data, o_valid, o_last, o_busy, o_overrun, o_overrun_cnt
    );
endinterface

// File: rtl/layer_out_serializer.sv
// Captures a packed NN-word layer output and replays it one word per valid/ready transfer.
// Define LAYER_SER_OVERRUN_CNT_EN to build the saturating dropped-capture counter.
module layer_out_serializer #(
    parameter int NN         = 30,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   s_axi_aclk,
    input  logic                   reset,
    layer_out_serializer_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NN - 1);

    state_t                    state_q, state_d;
    logic [NN*DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [CNT_WIDTH-1:0]      idx_q, idx_d;
    logic                      ovr_q, ovr_d;

    logic sending_w;
    logic last_w;
    logic xfer_w;
    logic capture_w;

    assign sending_w = (state_q == SEND);
    assign last_w    = (idx_q == LAST_IDX);
    assign xfer_w    = sending_w && bus.i_ready;
    // A capture landing on the final transfer chains the next frame with no bubble.
    assign capture_w = bus.i_valid && (!sending_w || (xfer_w && last_w));

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.i_valid)                         state_d = SEND;
            SEND: if (xfer_w && last_w && !bus.i_valid)    state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid = sending_w;
        bus.o_busy  = sending_w;
        bus.o_last  = sending_w && last_w;
        bus.o_data  = hold_q[DATA_WIDTH-1:0];
    end

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (capture_w) begin
            hold_d = bus.i_data;
            idx_d  = '0;
        end else if (xfer_w) begin
            hold_d = hold_q >> DATA_WIDTH;
            idx_d  = idx_q + CNT_WIDTH'(1);
        end
        ovr_d = bus.i_valid && !capture_w;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            hold_q <= '0;
            idx_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.o_overrun = ovr_q;

`ifdef LAYER_SER_OVERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ovr_d && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_overrun_cnt = cnt_q;
`else
    assign bus.o_overrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench: a frame-level model queues expected words, a monitor checks every cycle.
module tb_layer_out_serializer;
    localparam int NN = 4;
    localparam int DW = 16;
    localparam logic [NN*DW-1:0] F1 = 64'h0004_0003_0002_0001;
    localparam logic [NN*DW-1:0] F2 = 64'h0008_0007_0006_0005;
    localparam logic [NN*DW-1:0] FA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [NN*DW-1:0] F3 = 64'h000D_000C_000B_000A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_out_serializer_if #(.NN(NN), .DATA_WIDTH(DW)) bus();

    layer_out_serializer #(.NN(NN), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .s_axi_aclk (clk),
        .reset      (rst),
        .bus        (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    pending = 0;   // words of the current frame not yet transferred
    logic  exp_ovr = 1'b0;
    int    exp_cnt = 0;
    int    checks  = 0;
    int    fails   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a capture is taken when nothing is pending, or when the
    // single remaining word is being handed off this very cycle; otherwise it is dropped.
    always @(posedge clk) begin
        automatic bit xfer;
        automatic bit acc;
        if (rst) begin
            exp_q.delete();
            pending <= 0;
            exp_ovr <= 1'b0;
            exp_cnt <= 0;
        end else begin
            xfer = (pending > 0) && (bus.i_ready === 1'b1);
            acc  = (bus.i_valid === 1'b1) && (pending == 0 || (pending == 1 && xfer));
            if (acc)
                for (int k = 0; k < NN; k++)
                    exp_q.push_back('{bus.i_data[k*DW +: DW], (k == NN-1)});
            pending <= acc ? NN : pending - (xfer ? 1 : 0);
            exp_ovr <= (bus.i_valid === 1'b1) && !acc;
`ifdef LAYER_SER_OVERRUN_CNT_EN
            if ((bus.i_valid === 1'b1) && !acc && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
`endif
        end
    end

    always @(negedge clk) begin
        automatic word_t w;
        chk("o_valid", longint'(bus.o_valid), longint'(pending > 0));
        chk("o_busy", longint'(bus.o_busy), longint'(pending > 0));
        chk("o_overrun", longint'(bus.o_overrun), longint'(exp_ovr));
        chk("o_overrun_cnt", longint'(bus.o_overrun_cnt), longint'(exp_cnt));
        if (pending == 0) chk("o_last_idle", longint'(bus.o_last), 0);
        if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", longint'(bus.o_data), -1);
            end else begin
                w = exp_q.pop_front();
                chk("o_data", longint'(bus.o_data), longint'(w.data));
                chk("o_last", longint'(bus.o_last), longint'(w.last));
            end
        end
    end

    task automatic drive(input logic v, input logic [NN*DW-1:0] d, input logic r, input logic rs);
        @(posedge clk);
        #1;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        rst         = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // plain frame
        drive(1'b1, F1, 1'b1, 1'b0);
        idle(6);

        // backpressure at T+2, T+3
        drive(1'b1, F1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        idle(6);

        // overrun at T+2
        drive(1'b1, F1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, FA, 1'b1, 1'b0);
        idle(6);

        // chained frame on the last transfer
        drive(1'b1, F1, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, F2, 1'b1, 1'b0);
        idle(6);

        // reset mid-frame, then a fresh frame
        drive(1'b1, F1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        idle(1);
        drive(1'b1, F3, 1'b1, 1'b0);
        idle(6);

        // randomized traffic with occasional resets and back-to-back captures
        for (int i = 0; i < 3000; i++) begin
            automatic logic v  = ($urandom_range(0, 4) == 0) || (pending == 1 && $urandom_range(0, 2) == 0);
            automatic logic r  = ($urandom_range(0, 3) != 0);
            automatic logic rs = ($urandom_range(0, 299) == 0);
            drive(v, {$urandom, $urandom}, r, rs);
        end

        // bounded drain
        for (int i = 0; i < 4*NN && pending > 0; i++) idle(1);
        idle(2);
        chk("drain_pending", longint'(pending), 0);
        chk("drain_queue", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
